// File: rtl/ssd1306_pkg.sv
// Shared types and constants for the SSD1306 power-up and command sequencer.
package ssd1306_pkg;

    typedef enum logic [2:0] {
        PWR_VDD,
        RST_LOW,
        RST_REC,
        INIT,
        PWR_VBAT,
        DISP_ON,
        RUN
    } main_state_t;

    typedef enum logic [1:0] {
        XIDLE,
        XSTART,
        XBUSY,
        XDONE
    } xfer_state_t;

    localparam logic [7:0] CMD_DISPLAY_OFF = 8'hAE;
    localparam logic [7:0] CMD_DISPLAY_ON  = 8'hAF;
    localparam logic [7:0] CMD_NOP         = 8'hE3;
    localparam int         INIT_LEN        = 25;
    localparam logic [4:0] INIT_LAST_IDX   = 5'(INIT_LEN - 1);

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ssd1306_init_rom.sv
// Fixed SSD1306 init command list; indices past the end read as NOP.
module ssd1306_init_rom
    import ssd1306_pkg::*;
(
    input  logic [4:0] idx_i,
    output logic [7:0] byte_o
);

    // Index-to-byte lookup of the init command list.
    always_comb begin
        byte_o = CMD_NOP;
        case (idx_i)
            5'd0:  byte_o = CMD_DISPLAY_OFF;
            5'd1:  byte_o = 8'hD5;
            5'd2:  byte_o = 8'h80;
            5'd3:  byte_o = 8'hA8;
            5'd4:  byte_o = 8'h3F;
            5'd5:  byte_o = 8'hD3;
            5'd6:  byte_o = 8'h00;
            5'd7:  byte_o = 8'h40;
            5'd8:  byte_o = 8'h8D;
            5'd9:  byte_o = 8'h14;
            5'd10: byte_o = 8'h20;
            5'd11: byte_o = 8'h00;
            5'd12: byte_o = 8'hA1;
            5'd13: byte_o = 8'hC8;
            5'd14: byte_o = 8'hDA;
            5'd15: byte_o = 8'h12;
            5'd16: byte_o = 8'h81;
            5'd17: byte_o = 8'hCF;
            5'd18: byte_o = 8'hD9;
            5'd19: byte_o = 8'hF1;
            5'd20: byte_o = 8'hDB;
            5'd21: byte_o = 8'h40;
            5'd22: byte_o = 8'hA4;
            5'd23: byte_o = 8'hA6;
            5'd24: byte_o = 8'h2E;
            default: byte_o = CMD_NOP;
        endcase
    end

endmodule

// File: rtl/ssd1306_ctrl_seq.sv
// SSD1306 power-up sequencer and byte pump into shift_reg.
//
// state    | meaning
// PWR_VDD  | VDD on, reset released, waiting for VDD to settle
// RST_LOW  | panel reset held low
// RST_REC  | reset released, waiting before the first command
// INIT     | sending the init command list, one ROM byte per transfer
// PWR_VBAT | VBAT on, waiting for it to settle
// DISP_ON  | sending display-on
// RUN      | passing the frame byte stream through to shift_reg
//
// xstate   | meaning
// XIDLE    | no transfer in flight
// XSTART   | sr_start high for this one cycle
// XBUSY    | waiting for shift_reg to go busy
// XDONE    | waiting for shift_reg to return idle
module ssd1306_ctrl_seq
    import ssd1306_pkg::*;
#(
    parameter int VDD_SETTLE_CYCLES  = 12000,
    parameter int RST_LOW_CYCLES     = 48,
    parameter int RST_RECOVER_CYCLES = 48,
    parameter int VBAT_SETTLE_CYCLES = 1200000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    output logic       sr_start_o,
    output logic [7:0] sr_data_o,
    input  logic       sr_ready_i,
    output logic       oled_dnc_o,
    output logic       oled_nrst_o,
    output logic       oled_nvcd_o,
    output logic       oled_nvbat_o,
    input  logic       s_valid_i,
    input  logic [7:0] s_data_i,
    input  logic       s_dc_i,
    output logic       s_ready_o,
    output logic       init_done_o
);

    localparam int MAX_WAIT = max_int(max_int(VDD_SETTLE_CYCLES, RST_LOW_CYCLES),
                                      max_int(RST_RECOVER_CYCLES, VBAT_SETTLE_CYCLES));
    localparam int CNT_W = $clog2(MAX_WAIT) + 1;

    localparam logic [CNT_W-1:0] LD_VDD  = CNT_W'(VDD_SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_RLOW = CNT_W'(RST_LOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_RREC = CNT_W'(RST_RECOVER_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_VBAT = CNT_W'(VBAT_SETTLE_CYCLES - 1);

    main_state_t      state_q;
    xfer_state_t      xstate_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [4:0]       idx_q;
    logic [4:0]       idx_d;
    logic [7:0]       rom_byte;
    logic             xfer_done;

    logic             sr_start_q;
    logic [7:0]       sr_data_q;
    logic             oled_dnc_q;
    logic             oled_nrst_q;
    logic             oled_nvcd_q;
    logic             oled_nvbat_q;
    logic             s_ready_q;
    logic             init_done_q;

    ssd1306_init_rom u_rom (
        .idx_i  (idx_q),
        .byte_o (rom_byte)
    );

    assign cnt_d     = cnt_q - CNT_W'(1);
    assign idx_d     = idx_q + 5'd1;
    assign xfer_done = (xstate_q == XDONE) && sr_ready_i;

    // Main sequencer and transfer sub-FSM; every output is registered here.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= PWR_VDD;
            xstate_q     <= XIDLE;
            cnt_q        <= LD_VDD;
            idx_q        <= 5'd0;
            sr_start_q   <= 1'b0;
            sr_data_q    <= 8'h00;
            oled_dnc_q   <= 1'b0;
            oled_nrst_q  <= 1'b0;
            oled_nvcd_q  <= 1'b1;
            oled_nvbat_q <= 1'b1;
            s_ready_q    <= 1'b0;
            init_done_q  <= 1'b0;
        end else begin
            // Transfer progression; the main FSM below may override to start a new one.
            case (xstate_q)
                XSTART: begin
                    sr_start_q <= 1'b0;
                    xstate_q   <= XBUSY;
                end
                XBUSY:   if (!sr_ready_i) xstate_q <= XDONE;
                XDONE:   if (sr_ready_i)  xstate_q <= XIDLE;
                default: ;
            endcase

            case (state_q)
                PWR_VDD: begin
                    // The settle wait only starts counting once VDD is actually on.
                    if (oled_nvcd_q) begin
                        oled_nvcd_q <= 1'b0;
                        oled_nrst_q <= 1'b1;
                    end else if (cnt_q == '0) begin
                        state_q     <= RST_LOW;
                        oled_nrst_q <= 1'b0;
                        cnt_q       <= LD_RLOW;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                RST_LOW: begin
                    if (cnt_q == '0) begin
                        state_q     <= RST_REC;
                        oled_nrst_q <= 1'b1;
                        cnt_q       <= LD_RREC;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                RST_REC: begin
                    // idx_q is still 0 here, so rom_byte is the first init command.
                    if (cnt_q == '0) begin
                        state_q    <= INIT;
                        sr_start_q <= 1'b1;
                        sr_data_q  <= rom_byte;
                        oled_dnc_q <= 1'b0;
                        xstate_q   <= XSTART;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                INIT: begin
                    if (xfer_done) begin
                        if (idx_q == INIT_LAST_IDX) begin
                            state_q      <= PWR_VBAT;
                            oled_nvbat_q <= 1'b0;
                            cnt_q        <= LD_VBAT;
                        end else begin
                            idx_q <= idx_d;
                        end
                    end else if (xstate_q == XIDLE) begin
                        sr_start_q <= 1'b1;
                        sr_data_q  <= rom_byte;
                        oled_dnc_q <= 1'b0;
                        xstate_q   <= XSTART;
                    end
                end
                PWR_VBAT: begin
                    if (cnt_q == '0) begin
                        state_q    <= DISP_ON;
                        sr_start_q <= 1'b1;
                        sr_data_q  <= CMD_DISPLAY_ON;
                        oled_dnc_q <= 1'b0;
                        xstate_q   <= XSTART;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                DISP_ON: begin
                    if (xfer_done) begin
                        state_q     <= RUN;
                        init_done_q <= 1'b1;
                        s_ready_q   <= 1'b1;
                    end
                end
                RUN: begin
                    if (xfer_done) begin
                        s_ready_q <= 1'b1;
                    end else if ((xstate_q == XIDLE) && s_valid_i && s_ready_q) begin
                        s_ready_q  <= 1'b0;
                        sr_start_q <= 1'b1;
                        sr_data_q  <= s_data_i;
                        oled_dnc_q <= s_dc_i;
                        xstate_q   <= XSTART;
                    end
                end
                default: state_q <= PWR_VDD;
            endcase
        end
    end

    assign sr_start_o   = sr_start_q;
    assign sr_data_o    = sr_data_q;
    assign oled_dnc_o   = oled_dnc_q;
    assign oled_nrst_o  = oled_nrst_q;
    assign oled_nvcd_o  = oled_nvcd_q;
    assign oled_nvbat_o = oled_nvbat_q;
    assign s_ready_o    = s_ready_q;
    assign init_done_o  = init_done_q;

endmodule
